// File: rtl/matrix_alu_if.sv
// Sequencer/bus bundle for the matrix ALU.
// slave = ALU side, master = sequencer/memory side.
interface matrix_alu_if #(
  parameter int EW  = 16,
  parameter int OPW = 3
);
  logic             en_alu;
  logic [OPW-1:0]   op;
  logic [3:0]       s1;
  logic [7:0]       s2;
  logic [3:0]       dest;
  logic             alu_done;
  logic             alu_stop;
  logic [2:0]       alu_state;
  logic             r_en;
  logic             m_en;
  logic             r_rw;
  logic             m_rw;
  logic [1:0]       r_address;
  logic [2:0]       m_address;
  logic [16*EW-1:0] datain;
  logic [16*EW-1:0] dataout;

  modport slave (
    input  en_alu, op, s1, s2, dest, dataout,
    output alu_done, alu_stop, alu_state,
    output r_en, m_en, r_rw, m_rw,
    output r_address, m_address, datain
  );

  modport master (
    output en_alu, op, s1, s2, dest, dataout,
    input  alu_done, alu_stop, alu_state,
    input  r_en, m_en, r_rw, m_rw,
    input  r_address, m_address, datain
  );
endinterface

// File: rtl/matrix_alu.sv
// Matrix ALU: 4x4 x EW-bit ADD/SUB/MMUL/TRANS/SCALE.
// Ports: clk, alu_rst (async low), bus (matrix_alu_if.slave).
module matrix_alu #(
  parameter int EW  = 16,
  parameter int OPW = 3
) (
  input logic         clk,
  input logic         alu_rst,
  matrix_alu_if.slave bus
);
  localparam int MW = 16 * EW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
  localparam logic [OPW-1:0] OP_MMUL  = OPW'(3);
  localparam logic [OPW-1:0] OP_TRANS = OPW'(4);
  localparam logic [OPW-1:0] OP_SCALE = OPW'(5);
  localparam logic [OPW-1:0] OP_STOP  = OPW'(7);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [7:0]     s2_q, s2_d;
  logic [3:0]     dest_q, dest_d;
  logic [MW-1:0]  a_q, a_d;
  logic           done_q, done_d;
  logic           stop_q, stop_d;
  logic           r_en_q, r_en_d;
  logic           m_en_q, m_en_d;
  logic           r_rw_q, r_rw_d;
  logic           m_rw_q, m_rw_d;
  logic [1:0]     r_addr_q, r_addr_d;
  logic [2:0]     m_addr_q, m_addr_d;
  logic [MW-1:0]  datain_q, datain_d;

  logic           acc_en;
  logic           acc_rw;
  logic [3:0]     acc_f;
  logic [MW-1:0]  res;
  logic [EW-1:0]  dot;

  function automatic logic [EW-1:0] el(
    input logic [MW-1:0] w,
    input int            i,
    input int            j
  );
    return w[EW*(4*i+j) +: EW];
  endfunction

  function automatic logic is_exec(input logic [OPW-1:0] o);
    return (o >= OP_ADD) && (o <= OP_SCALE);
  endfunction

  function automatic logic is_bin(input logic [OPW-1:0] o);
    return (o >= OP_ADD) && (o <= OP_MMUL);
  endfunction

  // B is consumed straight off dataout during EXEC.
  always_comb begin
    res = '0;
    dot = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        dot = '0;
        for (int m = 0; m < 4; m++)
          dot = dot + el(a_q, i, m) * el(bus.dataout, m, j);
        unique case (op_q)
          OP_ADD:
            res[EW*(4*i+j) +: EW] =
              el(a_q, i, j) + el(bus.dataout, i, j);
          OP_SUB:
            res[EW*(4*i+j) +: EW] =
              el(a_q, i, j) - el(bus.dataout, i, j);
          OP_MMUL:
            res[EW*(4*i+j) +: EW] = dot;
          OP_TRANS:
            res[EW*(4*i+j) +: EW] = el(a_q, j, i);
          OP_SCALE:
            res[EW*(4*i+j) +: EW] = el(a_q, i, j) * EW'(s2_q);
          default:
            res[EW*(4*i+j) +: EW] = '0;
        endcase
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    s2_d     = s2_q;
    dest_d   = dest_q;
    a_d      = a_q;
    done_d   = 1'b0;
    stop_d   = stop_q;
    datain_d = '0;
    acc_en   = 1'b0;
    acc_rw   = 1'b1;
    acc_f    = '0;
    unique case (state_q)
      // DONE dispatches too, so a held en_alu runs back to back.
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.en_alu) begin
          op_d   = bus.op;
          s2_d   = bus.s2;
          dest_d = bus.dest;
          if (bus.op == OP_STOP) begin
            state_d = HALT;
            stop_d  = 1'b1;
          end else if (is_exec(bus.op)) begin
            state_d = FETCH1;
            acc_en  = 1'b1;
            acc_f   = bus.s1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      FETCH1: begin
        state_d = FETCH2;
        if (is_bin(op_q)) begin
          acc_en = 1'b1;
          acc_f  = s2_q[3:0];
        end
      end
      FETCH2: begin
        state_d = EXEC;
        a_d     = bus.dataout;
      end
      EXEC: begin
        state_d  = WRITE;
        datain_d = res;
        acc_en   = 1'b1;
        acc_rw   = 1'b0;
        acc_f    = dest_q;
      end
      WRITE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    r_en_d   = 1'b0;
    m_en_d   = 1'b0;
    r_rw_d   = 1'b1;
    m_rw_d   = 1'b1;
    r_addr_d = '0;
    m_addr_d = '0;
    if (acc_en) begin
      if (acc_f[3]) begin
        r_en_d   = 1'b1;
        r_rw_d   = acc_rw;
        r_addr_d = acc_f[1:0];
      end else begin
        m_en_d   = 1'b1;
        m_rw_d   = acc_rw;
        m_addr_d = acc_f[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge alu_rst) begin
    if (!alu_rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      s2_q     <= '0;
      dest_q   <= '0;
      a_q      <= '0;
      done_q   <= 1'b0;
      stop_q   <= 1'b0;
      r_en_q   <= 1'b0;
      m_en_q   <= 1'b0;
      r_rw_q   <= 1'b1;
      m_rw_q   <= 1'b1;
      r_addr_q <= '0;
      m_addr_q <= '0;
      datain_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      s2_q     <= s2_d;
      dest_q   <= dest_d;
      a_q      <= a_d;
      done_q   <= done_d;
      stop_q   <= stop_d;
      r_en_q   <= r_en_d;
      m_en_q   <= m_en_d;
      r_rw_q   <= r_rw_d;
      m_rw_q   <= m_rw_d;
      r_addr_q <= r_addr_d;
      m_addr_q <= m_addr_d;
      datain_q <= datain_d;
    end
  end

  assign bus.alu_state = state_q;
  assign bus.alu_done  = done_q;
  assign bus.alu_stop  = stop_q;
  assign bus.r_en      = r_en_q;
  assign bus.m_en      = m_en_q;
  assign bus.r_rw      = r_rw_q;
  assign bus.m_rw      = m_rw_q;
  assign bus.r_address = r_addr_q;
  assign bus.m_address = m_addr_q;
  assign bus.datain    = datain_q;
endmodule

// File: tb/tb_matrix_alu.sv
// Self-checking bench for matrix_alu with a
// matrix-level reference model and bus memories.
module tb_matrix_alu;
  localparam int EW = 16;
  localparam int MW = 256;

  logic clk = 1'b0;
  logic alu_rst;
  always #5 clk = ~clk;

  matrix_alu_if #(.EW(EW), .OPW(3)) bus ();

  matrix_alu #(.EW(EW), .OPW(3)) dut (
    .clk(clk),
    .alu_rst(alu_rst),
    .bus(bus)
  );

  logic [MW-1:0] mem [8];
  logic [MW-1:0] rf [4];
  logic [MW-1:0] rdata = '0;
  assign bus.dataout = rdata;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int overlap = 0;

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_rw) rdata <= mem[bus.m_address];
      else mem[bus.m_address] <= bus.datain;
    end
    if (bus.r_en) begin
      if (bus.r_rw) rdata <= rf[bus.r_address];
      else rf[bus.r_address] <= bus.datain;
    end
  end

  always @(negedge clk) begin
    if (bus.r_en && bus.m_en) overlap++;
    if ((bus.r_en && bus.r_rw) || (bus.m_en && bus.m_rw)) rd_cnt++;
    if ((bus.r_en && !bus.r_rw) || (bus.m_en && !bus.m_rw)) wr_cnt++;
    if (bus.alu_done) done_cnt++;
  end

  function automatic logic [MW-1:0] fill(input logic [15:0] v);
    logic [MW-1:0] w;
    for (int k = 0; k < 16; k++) w[16*k +: 16] = v;
    return w;
  endfunction

  function automatic logic [MW-1:0] seqm(input int step);
    logic [MW-1:0] w;
    for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'(step * k);
    return w;
  endfunction

  function automatic logic [MW-1:0] ident();
    logic [MW-1:0] w;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w[16*(4*i+j) +: 16] = (i == j) ? 16'd1 : 16'd0;
    return w;
  endfunction

  function automatic logic [MW-1:0] rnd_mat();
    logic [MW-1:0] w;
    for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
    return w;
  endfunction

  // Reference: unpack to 2-D integer matrices, do plain math, wrap.
  function automatic logic [MW-1:0] ref_op(
    input int op, input logic [MW-1:0] a,
    input logic [MW-1:0] b, input int k8
  );
    longint ea [4][4];
    longint eb [4][4];
    longint er [4][4];
    logic [MW-1:0] w;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ea[i][j] = longint'(a[16*(4*i+j) +: 16]);
        eb[i][j] = longint'(b[16*(4*i+j) +: 16]);
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        er[i][j] = 0;
        case (op)
          1: er[i][j] = ea[i][j] + eb[i][j];
          2: er[i][j] = ea[i][j] - eb[i][j];
          3: for (int m = 0; m < 4; m++)
               er[i][j] += ea[i][m] * eb[m][j];
          4: er[i][j] = ea[j][i];
          5: er[i][j] = ea[i][j] * k8;
          default: er[i][j] = 0;
        endcase
        w[16*(4*i+j) +: 16] = 16'(er[i][j] & 64'hFFFF);
      end
    return w;
  endfunction

  function automatic logic [MW-1:0] rd_loc(input logic [3:0] f);
    return f[3] ? rf[f[1:0]] : mem[f[2:0]];
  endfunction

  // Issue one instruction; lat = edges from sampling to alu_done,
  // -1 if it never came.
  task automatic run_instr(
    input logic [2:0] op, input logic [3:0] s1,
    input logic [7:0] s2, input logic [3:0] d, output int lat
  );
    @(negedge clk);
    bus.op = op; bus.s1 = s1; bus.s2 = s2; bus.dest = d;
    bus.en_alu = 1'b1;
    @(posedge clk); #1;
    bus.en_alu = 1'b0;
    bus.op = 3'($urandom); bus.s1 = 4'($urandom);
    bus.s2 = 8'($urandom); bus.dest = 4'($urandom);
    lat = 0;
    while (!bus.alu_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.alu_done) lat = -1;
  endtask

  task automatic test_reset();
    alu_rst = 1'b0;
    bus.en_alu = 1'b0; bus.op = '0; bus.s1 = '0;
    bus.s2 = '0; bus.dest = '0;
    #12;
    checks++;
    if (bus.alu_state !== 3'd0) begin
      errors++; $display("FAIL rst_state: got %0d exp 0", bus.alu_state);
    end
    checks++;
    if (bus.alu_done !== 1'b0 || bus.alu_stop !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got done=%b stop=%b exp 0 0",
                         bus.alu_done, bus.alu_stop);
    end
    checks++;
    if ({bus.r_en, bus.m_en, bus.r_rw, bus.m_rw} !== 4'b0011) begin
      errors++; $display("FAIL rst_ctl: got %b exp 0011",
                         {bus.r_en, bus.m_en, bus.r_rw, bus.m_rw});
    end
    checks++;
    if (bus.r_address !== 2'd0 || bus.m_address !== 3'd0 ||
        bus.datain !== '0) begin
      errors++; $display("FAIL rst_bus: got r=%0d m=%0d din=%h exp 0",
                         bus.r_address, bus.m_address, bus.datain);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) alu_rst = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    mem[0] = fill(16'd1); rf[2] = fill(16'd2); mem[1] = '0;
    run_instr(3'd1, 4'h0, 8'h0A, 4'h1, lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL add_latency: got %0d exp 4", lat);
    end
    checks++;
    if (mem[1] !== fill(16'd3)) begin
      errors++; $display("FAIL add_result: got %h exp %h", mem[1], fill(16'd3));
    end
    @(posedge clk); #1;
    checks++;
    if (bus.alu_done !== 1'b0 || bus.alu_state !== 3'd0) begin
      errors++; $display("FAIL add_done_pulse: got done=%b st=%0d exp 0 0",
                         bus.alu_done, bus.alu_state);
    end
  endtask

  task automatic test_sub_wrap();
    int lat;
    mem[2] = '0; rf[0] = fill(16'd1);
    run_instr(3'd2, 4'h2, 8'h08, 4'h9, lat);
    checks++;
    if (lat !== 4 || rf[1] !== fill(16'hFFFF)) begin
      errors++; $display("FAIL sub_wrap: got lat=%0d %h exp lat=4 %h",
                         lat, rf[1], fill(16'hFFFF));
    end
  endtask

  task automatic test_mmul();
    int lat;
    rf[3] = ident(); mem[4] = seqm(1);
    run_instr(3'd3, 4'hB, 8'h04, 4'h5, lat);
    checks++;
    if (lat !== 4 || mem[5] !== seqm(1)) begin
      errors++; $display("FAIL mmul_ident: got lat=%0d %h exp lat=4 %h",
                         lat, mem[5], seqm(1));
    end
    mem[6] = fill(16'h0100); mem[7] = fill(16'h0100);
    run_instr(3'd3, 4'h6, 8'h07, 4'h6, lat);
    checks++;
    if (mem[6] !== '0) begin
      errors++; $display("FAIL mmul_trunc: got %h exp 0", mem[6]);
    end
  endtask

  task automatic test_trans_scale();
    int lat, rd0, wr0;
    logic [MW-1:0] exp_t;
    mem[3] = seqm(1);
    exp_t = ref_op(4, seqm(1), '0, 0);
    run_instr(3'd4, 4'h3, 8'hF0, 4'hA, lat);
    checks++;
    if (rf[2] !== exp_t) begin
      errors++; $display("FAIL trans: got %h exp %h", rf[2], exp_t);
    end
    checks++;
    if (rf[2][16*1 +: 16] !== 16'd4 || rf[2][16*4 +: 16] !== 16'd1) begin
      errors++; $display("FAIL trans_elem: got e01=%0d e10=%0d exp 4 1",
                         rf[2][16*1 +: 16], rf[2][16*4 +: 16]);
    end
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_instr(3'd5, 4'h3, 8'h03, 4'h4, lat);
    checks++;
    if (mem[4] !== seqm(3)) begin
      errors++; $display("FAIL scale: got %h exp %h", mem[4], seqm(3));
    end
    checks++;
    if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1) begin
      errors++; $display("FAIL scale_reads: got rd=%0d wr=%0d exp 1 1",
                         rd_cnt - rd0, wr_cnt - wr0);
    end
  endtask

  task automatic test_nop();
    int lat, rd0, wr0;
    logic [2:0] ops [2];
    ops[0] = 3'd0; ops[1] = 3'd6;
    for (int n = 0; n < 2; n++) begin
      rd0 = rd_cnt; wr0 = wr_cnt;
      run_instr(ops[n], 4'h1, 8'h02, 4'h3, lat);
      checks++;
      if (lat !== 0) begin
        errors++; $display("FAIL nop_latency op%0d: got %0d exp 0", ops[n], lat);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.alu_done !== 1'b0 || rd_cnt != rd0 || wr_cnt != wr0) begin
        errors++; $display("FAIL nop_quiet op%0d: got done=%b rd=%0d wr=%0d exp 0 0 0",
                           ops[n], bus.alu_done, rd_cnt - rd0, wr_cnt - wr0);
      end
    end
  endtask

  task automatic test_random();
    int lat, rd0, wr0, op, bad;
    logic [3:0] s1, d;
    logic [7:0] s2;
    logic [MW-1:0] exp_r;
    bad = 0;
    for (int k = 0; k < 8; k++) mem[k] = rnd_mat();
    for (int k = 0; k < 4; k++) rf[k] = rnd_mat();
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(1, 5);
      s1 = 4'($urandom); s2 = 8'($urandom); d = 4'($urandom);
      exp_r = ref_op(op, rd_loc(s1), rd_loc(s2[3:0]), int'(s2));
      rd0 = rd_cnt; wr0 = wr_cnt;
      run_instr(3'(op), s1, s2, d, lat);
      checks++;
      if (lat !== 4 || rd_loc(d) !== exp_r ||
          rd_cnt - rd0 !== ((op <= 3) ? 2 : 1) || wr_cnt - wr0 !== 1) begin
        errors++; bad++;
        if (bad < 5)
          $display("FAIL random op%0d s1=%h s2=%h d=%h: got lat=%0d rd=%0d wr=%0d %h exp lat=4 %h",
                   op, s1, s2, d, lat, rd_cnt - rd0, wr_cnt - wr0, rd_loc(d), exp_r);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, cyc, wide;
    int t [3];
    logic prev;
    mem[0] = fill(16'd5); rf[1] = fill(16'd7); rf[2] = '0;
    n = 0; cyc = 0; wide = 0; prev = 1'b0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    @(negedge clk);
    bus.op = 3'd1; bus.s1 = 4'h0; bus.s2 = 8'h09; bus.dest = 4'hE;
    bus.en_alu = 1'b1;
    while (n < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.alu_done) begin
        if (prev) wide++;
        t[n] = cyc;
        n++;
      end
      prev = bus.alu_done;
    end
    bus.en_alu = 1'b0;
    checks++;
    if (n !== 3 || wide !== 0) begin
      errors++; $display("FAIL b2b_pulses: got n=%0d wide=%0d exp 3 0", n, wide);
    end
    checks++;
    if (t[1] - t[0] !== 5 || t[2] - t[1] !== 5) begin
      errors++; $display("FAIL b2b_spacing: got %0d %0d exp 5 5",
                         t[1] - t[0], t[2] - t[1]);
    end
    checks++;
    if (rf[2] !== fill(16'd12)) begin
      errors++; $display("FAIL b2b_result: got %h exp %h", rf[2], fill(16'd12));
    end
    @(posedge clk); #1;
    checks++;
    if (bus.alu_state !== 3'd0 || bus.alu_done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got st=%0d done=%b exp 0 0",
                         bus.alu_state, bus.alu_done);
    end
  endtask

  task automatic test_reset_mid();
    int wr0, d0;
    wr0 = wr_cnt; d0 = done_cnt;
    @(negedge clk);
    bus.op = 3'd1; bus.s1 = 4'h0; bus.s2 = 8'h09; bus.dest = 4'h2;
    bus.en_alu = 1'b1;
    @(posedge clk); #1;
    bus.en_alu = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.alu_state !== 3'd2) begin
      errors++; $display("FAIL mid_fetch2: got %0d exp 2", bus.alu_state);
    end
    #2 alu_rst = 1'b0;
    #1;
    checks++;
    if (bus.alu_state !== 3'd0 || bus.r_en !== 1'b0 || bus.m_en !== 1'b0) begin
      errors++; $display("FAIL mid_async: got st=%0d r_en=%b m_en=%b exp 0 0 0",
                         bus.alu_state, bus.r_en, bus.m_en);
    end
    @(negedge clk) alu_rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt != wr0 || done_cnt != d0 || bus.alu_state !== 3'd0) begin
      errors++; $display("FAIL mid_abort: got wr=%0d done=%0d st=%0d exp 0 0 0",
                         wr_cnt - wr0, done_cnt - d0, bus.alu_state);
    end
  endtask

  task automatic test_stop();
    int rd0, wr0, d0;
    @(negedge clk);
    bus.op = 3'd7; bus.en_alu = 1'b1;
    @(posedge clk); #1;
    bus.en_alu = 1'b0;
    checks++;
    if (bus.alu_stop !== 1'b1 || bus.alu_state !== 3'd6 || bus.alu_done !== 1'b0) begin
      errors++; $display("FAIL stop_enter: got stop=%b st=%0d done=%b exp 1 6 0",
                         bus.alu_stop, bus.alu_state, bus.alu_done);
    end
    rd0 = rd_cnt; wr0 = wr_cnt; d0 = done_cnt;
    @(negedge clk);
    bus.op = 3'd1; bus.s1 = 4'h0; bus.s2 = 8'h09; bus.dest = 4'h1;
    bus.en_alu = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.en_alu = 1'b0;
    checks++;
    if (bus.alu_state !== 3'd6 || bus.alu_stop !== 1'b1 ||
        rd_cnt != rd0 || wr_cnt != wr0 || done_cnt != d0) begin
      errors++; $display("FAIL stop_hold: got st=%0d stop=%b rd=%0d wr=%0d done=%0d exp 6 1 0 0 0",
                         bus.alu_state, bus.alu_stop, rd_cnt - rd0,
                         wr_cnt - wr0, done_cnt - d0);
    end
    alu_rst = 1'b0;
    #1;
    checks++;
    if (bus.alu_stop !== 1'b0 || bus.alu_state !== 3'd0) begin
      errors++; $display("FAIL stop_reset: got stop=%b st=%0d exp 0 0",
                         bus.alu_stop, bus.alu_state);
    end
    @(negedge clk) alu_rst = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = '0;
    for (int k = 0; k < 4; k++) rf[k] = '0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_mmul();
    test_trans_scale();
    test_nop();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_stop();
    checks++;
    if (overlap !== 0) begin
      errors++; $display("FAIL enable_overlap: got %0d cycles exp 0", overlap);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
